dmem_copy_engine: RTL and testbench

- Bus initiator on the single-port data-memory/IO bus: drives address, write data and write enable, and consumes read data.
- Copies a block of words from a source region to a destination region, or fills a destination region with a constant. The regions may be RAM or memory-mapped IO.
- Shares the bus with the CPU through a req/gnt handshake. The CPU-side arbiter muxes the engine's mem_addr/mem_wdata/mem_we onto the bus only while bus_gnt=1.

---
 rtl/dmem_copy_engine.sv | 131 +++++++++++++
 tb/tb_dmem_copy_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_copy_engine.sv
// Bus-initiator block engine: copies words from a source region to a destination region,
// or fills a destination region with a constant, sharing the data bus with the CPU via req/gnt.
module dmem_copy_engine #(
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             start,
    input  logic             fill,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      pattern,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_we,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             fill_q, fill_d;

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
        end
    end

    // Only mem_we looks at bus_gnt combinationally; everything else is decoded from state.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        fill_d    = fill_q;
        bus_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d  = {src_addr[31:2], 2'b00};
                    dst_d  = {dst_addr[31:2], 2'b00};
                    cnt_d  = len;
                    fill_d = fill;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (fill) begin
                        data_d  = pattern;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                busy     = 1'b1;
                bus_req  = 1'b1;
                mem_addr = src_q;
                if (bus_gnt) begin
                    data_d  = mem_rdata;
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                busy      = 1'b1;
                bus_req   = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = data_q;
                mem_we    = bus_gnt;
                if (bus_gnt) begin
                    src_d = src_q + 32'd4;
                    dst_d = dst_q + 32'd4;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else if (fill_q) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench: a word-array bus memory plus a queue of expected bus accesses built
// from the transfer description, checked every cycle on the falling edge.
module tb_dmem_copy_engine;

    localparam int LEN_W = 8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] dat;
    } acc_t;

    logic             clock = 1'b0;
    logic             clr, start, fill, bus_gnt;
    logic [31:0]      src_addr, dst_addr, pattern;
    logic [LEN_W-1:0] len;
    logic             bus_req, mem_we, busy, done;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    acc_t        exp_q[$];

    int   nchk = 0, nerr = 0;
    int   cyc = 0, st = 0, exp_dn = 0, gi = 0;
    int   nwr = 0, busy_cnt = 0, dn_off = -1;
    bit   act = 1'b0;
    logic [5:0] gpat = 6'h3F;

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr[9:2]];

    dmem_copy_engine #(.LEN_W(LEN_W)) dut (
        .clock     (clock),
        .clr       (clr),
        .start     (start),
        .fill      (fill),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .pattern   (pattern),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", n, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        mem[a[9:2]]     = d;
        ref_mem[a[9:2]] = d;
    endtask

    // Per-cycle comparison of every DUT output against the expected-access queue.
    task automatic check();
        acc_t e;
        bit   exp_busy, exp_req, exp_done;
        if (clr) begin
            chk("reset_ctl", {28'd0, bus_req, mem_we, busy, done}, 32'd0);
            chk("reset_addr", mem_addr, 32'd0);
            chk("reset_wdata", mem_wdata, 32'd0);
            return;
        end
        exp_busy = act && (cyc > st);
        exp_req  = exp_busy && (exp_q.size() > 0);
        chk("busy", busy, exp_busy);
        chk("bus_req", bus_req, exp_req);
        if (!bus_gnt) chk("we_without_gnt", mem_we, 1'b0);
        if (bus_req && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("mem_addr", mem_addr, e.addr);
            if (bus_gnt) begin
                chk("mem_we", mem_we, e.we);
                if (e.we) chk("mem_wdata", mem_wdata, e.dat);
                exp_q.delete(0);
                if (exp_q.size() == 0) exp_dn = cyc + 1;
            end
        end
        if (bus_gnt && mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            nwr++;
        end
        exp_done = act && (cyc == exp_dn);
        chk("done", done, exp_done);
        if (busy) busy_cnt++;
        if (exp_done) begin
            act    = 1'b0;
            dn_off = cyc - st;
        end
    endtask

    task automatic step();
        @(negedge clock);
        check();
        @(posedge clock);
        cyc++;
        #1;
        bus_gnt = gpat[gi % 6];
        gi++;
    endtask

    task automatic run(input bit f, input logic [31:0] s, input logic [31:0] d, input int n,
                       input logic [31:0] p, input logic [5:0] gp, input int pulse_at,
                       input int clr_at);
        logic [31:0] a, b, v;
        int t;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            b = {d[31:2], 2'b00} + 32'(4 * i);
            if (f) begin
                exp_q.push_back('{1'b1, b, p});
            end else begin
                a = {s[31:2], 2'b00} + 32'(4 * i);
                v = ref_mem[a[9:2]];
                exp_q.push_back('{1'b0, a, 32'd0});
                exp_q.push_back('{1'b1, b, v});
                ref_mem[b[9:2]] = v;
            end
        end
        fill = f; src_addr = s; dst_addr = d; len = n[LEN_W-1:0]; pattern = p;
        start = 1'b1;
        gpat = gp; gi = 0;
        act = 1'b1; st = cyc; exp_dn = (n == 0) ? st + 1 : 32'h4000_0000;
        nwr = 0; busy_cnt = 0; dn_off = -1;
        t = 0;
        do begin
            step();
            start = 1'b0;
            t++;
            if (cyc - st == pulse_at) begin
                start = 1'b1; fill = 1'b1; dst_addr = 32'h200; len = 8'd5; pattern = 32'hBAD0BAD0;
            end
            if (cyc - st == clr_at) begin
                clr = 1'b1;
                act = 1'b0;
                exp_q.delete();
                step();
                step();
                clr = 1'b0;
                for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
            end
        end while (act && t < 300);
        if (act) begin
            nchk++; nerr++;
            $display("FAIL timeout waiting for done: got none within %0d cycles", t);
            act = 1'b0;
        end
        step();
        start = 1'b0;
        gpat = 6'h3F;
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired: got no summary, expected completion");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; start = 1'b0; fill = 1'b0; bus_gnt = 1'b1;
        src_addr = '0; dst_addr = '0; len = '0; pattern = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        poke(32'h00, 32'h11); poke(32'h04, 32'h22); poke(32'h08, 32'h33); poke(32'h0C, 32'h44);
        poke(32'h2C, 32'h5555_5555);
        poke(32'hFFFF_FFFC, 32'hA5A5_A5A5);
        poke(32'h100, 32'd1); poke(32'h104, 32'd2); poke(32'h108, 32'd3); poke(32'h10C, 32'd4);
        step();
        step();
        clr = 1'b0;
        step();
        step();

        // Copy of 4 words, full grant.
        run(1'b0, 32'h00, 32'h40, 4, 32'd0, 6'h3F, -1, -1);
        chk("copy_done_cycle", dn_off, 32'd9);
        chk("copy_writes", nwr, 32'd4);
        chk("copy_w0", rd(32'h40), 32'h11);
        chk("copy_w1", rd(32'h44), 32'h22);
        chk("copy_w2", rd(32'h48), 32'h33);
        chk("copy_w3", rd(32'h4C), 32'h44);

        // Fill of 3 words.
        run(1'b1, 32'h00, 32'h20, 3, 32'hDEAD_BEEF, 6'h3F, -1, -1);
        chk("fill_done_cycle", dn_off, 32'd4);
        chk("fill_writes", nwr, 32'd3);
        chk("fill_w0", rd(32'h20), 32'hDEAD_BEEF);
        chk("fill_w2", rd(32'h28), 32'hDEAD_BEEF);
        chk("fill_past_end", rd(32'h2C), 32'h5555_5555);

        // Grant toggling 1,0,0,1,0,1,...
        run(1'b0, 32'h00, 32'h60, 2, 32'd0, 6'b101001, -1, -1);
        chk("stall_writes", nwr, 32'd2);
        chk("stall_w0", rd(32'h60), 32'h11);
        chk("stall_w1", rd(32'h64), 32'h22);

        // Zero length; a start during the done cycle must be ignored.
        run(1'b0, 32'h00, 32'h70, 0, 32'd0, 6'h3F, 1, -1);
        chk("len0_done_cycle", dn_off, 32'd1);
        chk("len0_busy_cycles", busy_cnt, 32'd1);
        chk("len0_writes", nwr, 32'd0);
        chk("ignored_start_mem", rd(32'h200), 32'd0);

        // Unaligned addresses with source wrap past 0xFFFFFFFC.
        run(1'b0, 32'hFFFF_FFFD, 32'h13, 2, 32'd0, 6'h3F, -1, -1);
        chk("wrap_w0", rd(32'h10), 32'hA5A5_A5A5);
        chk("wrap_w1", rd(32'h14), 32'h11);

        // Reset during the second write of a 4-word copy.
        run(1'b0, 32'h00, 32'h80, 4, 32'd0, 6'h3F, -1, 4);
        chk("abort_writes", nwr, 32'd1);
        chk("abort_no_done", dn_off, 32'hFFFF_FFFF);
        chk("abort_w0", rd(32'h80), 32'h11);
        chk("abort_w1", rd(32'h84), 32'd0);

        // Normal run after reset, with a start pulsed while busy.
        run(1'b0, 32'h00, 32'h90, 2, 32'd0, 6'h3F, 2, -1);
        chk("post_done_cycle", dn_off, 32'd5);
        chk("post_w1", rd(32'h94), 32'h22);
        chk("busy_start_mem", rd(32'h200), 32'd0);

        // Overlap with dst = src + 4: first word propagates.
        run(1'b0, 32'h100, 32'h104, 3, 32'd0, 6'h3F, -1, -1);
        chk("overlap_w0", rd(32'h104), 32'd1);
        chk("overlap_w2", rd(32'h10C), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
